// File: rtl/avalon_pkg.sv
// Shared Avalon-ST definitions: default sizing and the width rule for the
// 'empty' field (number of unused trailing bytes in an end-of-packet word).
package avalon_pkg;

  localparam int DEFAULT_DATA_WIDTH_IN_BYTES = 16;
  localparam int DEFAULT_FIFO_DEPTH          = 16;

  // Width of the empty field; a one-byte bus still carries a 1-bit field
  // so that the port never collapses to zero width.
  function automatic int empty_width(input int bytes);
    if (bytes > 1) begin
      return $clog2(bytes);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming interface: data plus sop/eop/empty framing and a
// valid/rdy handshake. The master drives the payload and valid, and the
// slave drives rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = avalon_pkg::DEFAULT_DATA_WIDTH_IN_BYTES
);
  import avalon_pkg::*;

  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             valid;
  logic                             rdy;

  modport master (output data, output sop, output eop, output empty, output valid, input rdy);
  modport slave  (input data, input sop, input eop, input empty, input valid, output rdy);

endinterface

// File: rtl/avalon_st_fifo_mem.sv
// Storage array for avalon_st_fifo. It has one synchronous write port and one
// asynchronous read port. The contents are never reset: the control logic
// only exposes an entry after that entry has been written.
module avalon_st_fifo_mem
  import avalon_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture the incoming word into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The show-ahead head word is read directly from the registered array.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/avalon_st_fifo.sv
// Avalon-ST show-ahead FIFO. Its latency is one cycle, and no combinational
// path runs from input to output. Both handshake outputs are decoded from the
// registered fill level only. Defining macro AVALON_ST_FIFO_PKT_CNT_EN adds
// the packets_stored port, which counts the stored words that carry eop.
module avalon_st_fifo
  import avalon_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = DEFAULT_DATA_WIDTH_IN_BYTES,
  parameter int DEPTH               = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  avalon_st_if.slave             msg_in,
  avalon_st_if.master            msg_out,
  output logic [$clog2(DEPTH):0] fill_level
`ifdef AVALON_ST_FIFO_PKT_CNT_EN
  ,
  output logic [$clog2(DEPTH):0] packets_stored
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int EW     = empty_width(DATA_WIDTH_IN_BYTES);
  localparam int DW     = 8 * DATA_WIDTH_IN_BYTES;
  localparam int WORD_W = DW + 2 + EW;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic              in_rdy_s;
  logic              out_valid_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [WORD_W-1:0] wr_word_s;
  logic [WORD_W-1:0] rd_word_s;

  // Both handshakes depend only on the registered level. While the FIFO is
  // full, a read in the same cycle does not reopen rdy until the next cycle.
  assign in_rdy_s    = (fill_q != FULL_LVL);
  assign out_valid_s = (fill_q != {CW{1'b0}});
  assign wr_en_s     = msg_in.valid & in_rdy_s;
  assign rd_en_s     = out_valid_s & msg_out.rdy;

  assign msg_in.rdy    = in_rdy_s;
  assign msg_out.valid = out_valid_s;
  assign fill_level    = fill_q;

  // Fields are stored exactly as received and replayed unchanged.
  assign wr_word_s = {msg_in.data, msg_in.sop, msg_in.eop, msg_in.empty};
  assign {msg_out.data, msg_out.sop, msg_out.eop, msg_out.empty} = rd_word_s;

  avalon_st_fifo_mem #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word_s)
  );

  // Next-state pointers and level. DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   fill_d = fill_q + CNT_ONE;
      2'b01:   fill_d = fill_q - CNT_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and level registers. Reset discards every stored word, including any partial packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      fill_q   <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

`ifdef AVALON_ST_FIFO_PKT_CNT_EN
  logic [CW-1:0] pkt_q, pkt_d;
  logic          eop_wr_s;
  logic          eop_rd_s;

  assign eop_wr_s       = wr_en_s & msg_in.eop;
  assign eop_rd_s       = rd_en_s & msg_out.eop;
  assign packets_stored = pkt_q;

  // Count of stored eop words. It is unchanged when one enters and one leaves in the same cycle.
  always_comb begin
    pkt_d = pkt_q;
    case ({eop_wr_s, eop_rd_s})
      2'b10:   pkt_d = pkt_q + CNT_ONE;
      2'b01:   pkt_d = pkt_q - CNT_ONE;
      default: pkt_d = pkt_q;
    endcase
  end

  // Packet-count register, which is cleared together with the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q <= {CW{1'b0}};
    end else begin
      pkt_q <= pkt_d;
    end
  end
`endif

endmodule
